pe_mac_os: RTL and testbench
============================

Name: pe_mac_os

Overview:
- Parametrised output-stationary systolic processing element; successor to the plain pass-through PE.
- Forwards operand data plus valid flags right and down with one-cycle registration.
- Performs signed multiply-accumulate when both operands are valid.
- Drains its accumulator, and then the partial sums of the PEs above it, down a dedicated psum column chain under a small FSM.

Parameters:
- DATA_WIDTH, 16, operand width (signed two's complement).
- ACC_WIDTH, 40, accumulator and psum width; must be >= 2*DATA_WIDTH.
- CNT_WIDTH, 6, width of the drain forward counter; supports up to 2^CNT_WIDTH-1 upstream PEs.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_accumulator  input  1  synchronous, active-high reset of all state.
- input_top  input  DATA_WIDTH  operand from PE above.
- valid_top  input  1  input_top valid.
- input_left  input  DATA_WIDTH  operand from PE to the left.
- valid_left  input  1  input_left valid.
- output_bottom  output  DATA_WIDTH  registered input_top.
- valid_bottom  output  1  registered valid_top.
- output_right  output  DATA_WIDTH  registered input_left.
- valid_right  output  1  registered valid_left.
- acc_clear  input  1  synchronous accumulator clear; does not affect forwarding.
- drain_start  input  1  single-cycle pulse; starts drain.
- fwd_count  input  CNT_WIDTH  number of upstream psums to forward; sampled on accepted drain_start.
- psum_in  input  ACC_WIDTH  psum from PE above.
- psum_in_valid  input  1  psum_in valid.
- psum_out  output  ACC_WIDTH  psum to PE below.
- psum_out_valid  output  1  psum_out valid.
- busy  output  1  high while FSM not IDLE.

Behaviour:
- Reset (reset_accumulator=1): all outputs, acc, drain register and counter = 0; FSM -> IDLE. Reset overrides every other input, including mid-drain.
- Forwarding, every cycle, latency 1:
  - output_bottom<=input_top, valid_bottom<=valid_top.
  - output_right<=input_left, valid_right<=valid_left.
  - Data registers update regardless of valid.
- MAC: when valid_top & valid_left, prod = signed(input_top)*signed(input_left) (2*DATA_WIDTH), sign-extended to ACC_WIDTH; acc <= acc + prod, wrapping modulo 2^ACC_WIDTH. If either valid is low, acc holds.
- Priority for acc, highest first: reset > drain_start accepted > acc_clear > MAC.
  - acc_clear with a valid MAC in the same cycle: acc <= prod.
  - acc_clear alone: acc <= 0.
- FSM states: IDLE, EMIT, FORWARD.
  - IDLE: drain_start=1 -> drain_reg <= acc + (prod if MAC valid this cycle, else 0); acc <= 0; cnt <= fwd_count; go EMIT. acc_clear in the same cycle is redundant.
  - EMIT, one cycle: psum_out=drain_reg, psum_out_valid=1. Then go FORWARD if cnt!=0, else IDLE.
  - FORWARD: each cycle with psum_in_valid=1, psum_out<=psum_in, psum_out_valid<=1 (one-cycle latency) and cnt decrements. When a forward occurs with cnt==1, go IDLE. Cycles with psum_in_valid=0 give psum_out_valid=0 and leave the counter unchanged.
  - psum_in_valid in IDLE or EMIT: ignored, not forwarded.
- Overlap and busy:
  - drain_start while busy: ignored; no state change.
  - MAC continues during EMIT/FORWARD into the freshly cleared acc, so the next tile can stream while the previous one drains.
  - busy=1 in EMIT and FORWARD.
- psum_out holds its last value when psum_out_valid=0.

Optional Feature:
- PE_MAC_SAT_EN defined: accumulation (including the drain_start fold-in) saturates at the signed ACC_WIDTH limits 2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1).
  - Adds output sat_flag, 1 bit: sticky, set on any saturating add, cleared by reset, acc_clear or an accepted drain_start.
- Not defined: wrap-around arithmetic and no sat_flag port.

Test Plan:
- Reset then 4 cycles of valid_top=valid_left=1 with top=3,left=-2 -> acc=-24. Pulse drain_start with fwd_count=0 -> psum_out=-24 with psum_out_valid=1 for exactly one cycle, busy=1 for one cycle, then IDLE.
- Forwarding: input_top=0x1234, valid_top=1, input_left=0xABCD, valid_left=0 -> next cycle output_bottom=0x1234, valid_bottom=1, output_right=0xABCD, valid_right=0, acc unchanged.
- Drain with fwd_count=2: EMIT own psum 100; psum_in=7 valid, one idle gap, psum_in=9 valid -> psum_out sequence 100, 7, (valid 0), 9. FSM returns to IDLE after the 9. A third psum_in_valid is not forwarded.
- Simultaneous events:
  - drain_start with MAC 5*5 and acc=10 -> emitted 35, acc=0.
  - acc_clear with MAC 2*3 and acc=50 -> acc=6.
  - drain_start during FORWARD -> ignored.
- reset_accumulator asserted mid-FORWARD -> next cycle all outputs 0, busy=0. A subsequent drain_start is accepted normally.
- DATA_WIDTH=16, ACC_WIDTH=32, repeated MACs of 32767*32767:
  - with PE_MAC_SAT_EN: clamps at 2147483647, sat_flag=1.
  - without: wraps to a negative value.

Source files
------------

// File: rtl/pe_mac_os.sv
// pe_mac_os: output-stationary systolic processing element.
//   - Registers operands (and their valid flags) through to the right and bottom neighbours.
//   - Accumulates signed products of the top and left operands when both are valid.
//   - On drain_start it emits its own accumulator down the psum column.
//     It then forwards fwd_count partial sums arriving from the PEs above.
// Optional build macro: PE_MAC_SAT_EN.
//   - Accumulation saturates at the signed ACC_WIDTH limits.
//   - Adds a sticky sat_flag output.
// Ports:
//   clk                      rising-edge clock
//   reset_accumulator        synchronous active-high reset of all state
//   input_top/valid_top      operand from above  -> output_bottom/valid_bottom (1-cycle)
//   input_left/valid_left    operand from left   -> output_right/valid_right   (1-cycle)
//   acc_clear                synchronous accumulator clear
//   drain_start, fwd_count   start a drain; number of upstream psums to forward
//   psum_in/psum_in_valid    psum chain from the PE above
//   psum_out/psum_out_valid  psum chain to the PE below
//   busy                     drain in progress
//   sat_flag                 (PE_MAC_SAT_EN only) sticky saturation indicator
module pe_mac_os #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_accumulator,
  input  logic [DATA_WIDTH-1:0] input_top,
  input  logic                  valid_top,
  input  logic [DATA_WIDTH-1:0] input_left,
  input  logic                  valid_left,
  output logic [DATA_WIDTH-1:0] output_bottom,
  output logic                  valid_bottom,
  output logic [DATA_WIDTH-1:0] output_right,
  output logic                  valid_right,
  input  logic                  acc_clear,
  input  logic                  drain_start,
  input  logic [CNT_WIDTH-1:0]  fwd_count,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_in_valid,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_out_valid,
  output logic                  busy
`ifdef PE_MAC_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FORWARD} state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [DATA_WIDTH-1:0]         r_bottom;
  logic                          r_vbottom;
  logic [DATA_WIDTH-1:0]         r_right;
  logic                          r_vright;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]          r_psum;
  logic                          r_psum_valid;
  logic [CNT_WIDTH-1:0]          r_cnt;

  logic                          w_mac;
  logic                          w_drain_go;
  logic signed [2*DATA_WIDTH-1:0] w_top_ext;
  logic signed [2*DATA_WIDTH-1:0] w_left_ext;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_addend;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;

  assign w_mac      = valid_top & valid_left;
  assign w_drain_go = (r_state == S_IDLE) & drain_start;

  assign w_top_ext  = (2*DATA_WIDTH)'($signed(input_top));
  assign w_left_ext = (2*DATA_WIDTH)'($signed(input_left));
  assign w_prod     = w_top_ext * w_left_ext;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_addend   = w_mac ? w_prod_ext : '0;
  assign w_sum      = r_acc + w_addend;

`ifdef PE_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic w_ovf;
  logic r_sat;

  // Overflow only when both addends share a sign that the sum does not.
  assign w_ovf      = (r_acc[ACC_WIDTH-1] == w_addend[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
  assign w_acc_next = w_ovf ? (r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_sum;
  assign sat_flag   = r_sat;

  // An accepted drain restarts the flag, but a saturating fold-in on that
  // same cycle is still reported.
  always_ff @(posedge clk) begin
    if (reset_accumulator)  r_sat <= 1'b0;
    else if (w_drain_go)    r_sat <= w_ovf;
    else if (acc_clear)     r_sat <= 1'b0;
    else if (w_ovf)         r_sat <= 1'b1;
  end
`else
  assign w_acc_next = w_sum;
`endif

  // Operand forwarding
  always_ff @(posedge clk) begin
    if (reset_accumulator) begin
      r_bottom  <= '0;
      r_vbottom <= 1'b0;
      r_right   <= '0;
      r_vright  <= 1'b0;
    end else begin
      r_bottom  <= input_top;
      r_vbottom <= valid_top;
      r_right   <= input_left;
      r_vright  <= valid_left;
    end
  end

  // Accumulator: reset > drain > clear > MAC
  always_ff @(posedge clk) begin
    if (reset_accumulator) r_acc <= '0;
    else if (w_drain_go)   r_acc <= '0;
    else if (acc_clear)    r_acc <= w_mac ? w_prod_ext : '0;
    else if (w_mac)        r_acc <= w_acc_next;
  end

  // psum_out doubles as the drain register: the folded accumulator is loaded
  // on drain acceptance, so it is presented during the EMIT cycle.
  always_ff @(posedge clk) begin
    if (reset_accumulator) begin
      r_psum       <= '0;
      r_psum_valid <= 1'b0;
    end else begin
      r_psum_valid <= 1'b0;
      if (w_drain_go) begin
        r_psum       <= w_acc_next;
        r_psum_valid <= 1'b1;
      end else if ((r_state == S_FORWARD) && psum_in_valid) begin
        r_psum       <= psum_in;
        r_psum_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_accumulator)                         r_cnt <= '0;
    else if (w_drain_go)                           r_cnt <= fwd_count;
    else if ((r_state == S_FORWARD) && psum_in_valid) r_cnt <= r_cnt - CNT_WIDTH'(1);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset_accumulator) r_state <= S_IDLE;
    else                   r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (drain_start) w_state_next = S_EMIT;
      S_EMIT:    w_state_next = (r_cnt != '0) ? S_FORWARD : S_IDLE;
      S_FORWARD: if (psum_in_valid && (r_cnt == CNT_WIDTH'(1))) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  assign output_bottom  = r_bottom;
  assign valid_bottom   = r_vbottom;
  assign output_right   = r_right;
  assign valid_right    = r_vright;
  assign psum_out       = r_psum;
  assign psum_out_valid = r_psum_valid;

endmodule

// File: tb/tb_pe_mac_os.sv
module tb_pe_mac_os;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_accumulator;
  logic [DW-1:0] input_top, input_left;
  logic          valid_top, valid_left;
  logic          acc_clear, drain_start;
  logic [CW-1:0] fwd_count;
  logic [AW-1:0] psum_in;
  logic          psum_in_valid;

  logic [DW-1:0] output_bottom, output_right;
  logic          valid_bottom, valid_right;
  logic [AW-1:0] psum_out;
  logic          psum_out_valid, busy;

  logic [DW-1:0] ob32, or32;
  logic          vb32, vr32;
  logic [31:0]   po32;
  logic          pv32, busy32;
`ifdef PE_MAC_SAT_EN
  logic          sat_flag, sat32;
`endif

  pe_mac_os #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset_accumulator(reset_accumulator),
    .input_top(input_top), .valid_top(valid_top),
    .input_left(input_left), .valid_left(valid_left),
    .output_bottom(output_bottom), .valid_bottom(valid_bottom),
    .output_right(output_right), .valid_right(valid_right),
    .acc_clear(acc_clear), .drain_start(drain_start), .fwd_count(fwd_count),
    .psum_in(psum_in), .psum_in_valid(psum_in_valid),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid), .busy(busy)
`ifdef PE_MAC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  pe_mac_os #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .CNT_WIDTH(CW)) u_dut32 (
    .clk(clk), .reset_accumulator(reset_accumulator),
    .input_top(input_top), .valid_top(valid_top),
    .input_left(input_left), .valid_left(valid_left),
    .output_bottom(ob32), .valid_bottom(vb32),
    .output_right(or32), .valid_right(vr32),
    .acc_clear(acc_clear), .drain_start(drain_start), .fwd_count(fwd_count),
    .psum_in(psum_in[31:0]), .psum_in_valid(psum_in_valid),
    .psum_out(po32), .psum_out_valid(pv32), .busy(busy32)
`ifdef PE_MAC_SAT_EN
    , .sat_flag(sat32)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model of the 40-bit PE: the accumulator as a plain integer,
  // the drain as "emit pending" plus "forwards remaining".
  longint        m_acc = 0;
  bit            m_emit = 0;
  int            m_rem = 0;
  logic [DW-1:0] e_bottom = '0, e_right = '0;
  logic          e_vb = 0, e_vr = 0;
  logic [AW-1:0] e_po = '0;
  logic          e_pv = 0, e_busy = 0;

  function automatic longint wrap40(input longint v);
    longint t;
    t = v <<< (64 - AW);
    return t >>> (64 - AW);
  endfunction

  task automatic model_step();
    longint prod, folded;
    bit mac, was_busy;
    prod = longint'($signed(input_top)) * longint'($signed(input_left));
    mac  = valid_top && valid_left;
    if (reset_accumulator) begin
      m_acc = 0; m_emit = 0; m_rem = 0;
      e_bottom = '0; e_right = '0; e_vb = 0; e_vr = 0; e_po = '0; e_pv = 0;
    end else begin
      was_busy = m_emit || (m_rem > 0);
      e_bottom = input_top; e_vb = valid_top;
      e_right = input_left; e_vr = valid_left;
      e_pv = 0;
      if (m_emit) m_emit = 0;
      else if (m_rem > 0 && psum_in_valid) begin
        e_po = psum_in; e_pv = 1; m_rem--;
      end
      if (drain_start && !was_busy) begin
        folded = wrap40(m_acc + (mac ? prod : 0));
        e_po = folded[AW-1:0]; e_pv = 1;
        m_acc = 0; m_emit = 1; m_rem = int'(fwd_count);
      end else if (acc_clear) m_acc = mac ? prod : 0;
      else if (mac) m_acc = wrap40(m_acc + prod);
    end
    e_busy = m_emit || (m_rem > 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    input_top = '0; input_left = '0; valid_top = 0; valid_left = 0;
    acc_clear = 0; drain_start = 0; fwd_count = '0; psum_in = '0; psum_in_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_accumulator = 1; tick(); reset_accumulator = 0;
  endtask

  task automatic mac_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
    input_top = a; input_left = b; valid_top = 1; valid_left = 1;
    repeat (n) tick();
    valid_top = 0; valid_left = 0;
  endtask

  task automatic test_reset();
    input_top = 16'h5A5A; input_left = 16'hA5A5; valid_top = 1; valid_left = 1;
    drain_start = 1; psum_in = 40'h12_3456_789A; psum_in_valid = 1; acc_clear = 0;
    reset_accumulator = 1; tick(); reset_accumulator = 0;
    idle_inputs();
    checks++; if (output_bottom !== '0 || valid_bottom !== 1'b0) begin failures++; $display("FAIL reset_bottom got=%h/%b exp=0/0", output_bottom, valid_bottom); end
    checks++; if (output_right !== '0 || valid_right !== 1'b0) begin failures++; $display("FAIL reset_right got=%h/%b exp=0/0", output_right, valid_right); end
    checks++; if (psum_out !== '0 || psum_out_valid !== 1'b0) begin failures++; $display("FAIL reset_psum got=%h/%b exp=0/0", psum_out, psum_out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef PE_MAC_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
`endif
  endtask

  task automatic test_mac_drain();
    do_reset();
    mac_op(16'd3, -16'sd2, 4);
    drain_start = 1; fwd_count = '0; tick(); drain_start = 0;
    checks++; if (longint'($signed(psum_out)) !== -64'sd24 || psum_out_valid !== 1'b1) begin failures++; $display("FAIL mac_emit got=%0d/%b exp=-24/1", $signed(psum_out), psum_out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mac_busy got=%b exp=1", busy); end
    tick();
    checks++; if (psum_out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mac_done got=%b/%b exp=0/0", psum_out_valid, busy); end
  endtask

  task automatic test_forward_drain();
    do_reset();
    mac_op(16'd10, 16'd10, 1);
    input_top = 16'h1234; valid_top = 1; input_left = 16'hABCD; valid_left = 0; tick();
    checks++; if (output_bottom !== 16'h1234 || valid_bottom !== 1'b1) begin failures++; $display("FAIL fwd_bottom got=%h/%b exp=1234/1", output_bottom, valid_bottom); end
    checks++; if (output_right !== 16'hABCD || valid_right !== 1'b0) begin failures++; $display("FAIL fwd_right got=%h/%b exp=abcd/0", output_right, valid_right); end
    idle_inputs();
    drain_start = 1; fwd_count = 6'd2; tick(); drain_start = 0;
    checks++; if (psum_out !== 40'd100 || psum_out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL drain_emit got=%0d/%b/%b exp=100/1/1", psum_out, psum_out_valid, busy); end
    psum_in = 40'd55; psum_in_valid = 1; tick();
    checks++; if (psum_out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drain_emit_ignore got=%b/%b exp=0/1", psum_out_valid, busy); end
    psum_in = 40'd7; tick();
    checks++; if (psum_out !== 40'd7 || psum_out_valid !== 1'b1) begin failures++; $display("FAIL drain_fwd7 got=%0d/%b exp=7/1", psum_out, psum_out_valid); end
    psum_in = 40'd123; psum_in_valid = 0; tick();
    checks++; if (psum_out !== 40'd7 || psum_out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drain_gap got=%0d/%b/%b exp=7/0/1", psum_out, psum_out_valid, busy); end
    psum_in = 40'd9; psum_in_valid = 1; tick();
    checks++; if (psum_out !== 40'd9 || psum_out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL drain_fwd9 got=%0d/%b/%b exp=9/1/0", psum_out, psum_out_valid, busy); end
    psum_in = 40'd11; tick(); psum_in_valid = 0;
    checks++; if (psum_out !== 40'd9 || psum_out_valid !== 1'b0) begin failures++; $display("FAIL drain_extra got=%0d/%b exp=9/0", psum_out, psum_out_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mac_op(16'd5, 16'd2, 1);
    input_top = 16'd5; input_left = 16'd5; valid_top = 1; valid_left = 1;
    drain_start = 1; fwd_count = '0; tick(); idle_inputs();
    checks++; if (psum_out !== 40'd35 || psum_out_valid !== 1'b1) begin failures++; $display("FAIL sim_drain_fold got=%0d/%b exp=35/1", psum_out, psum_out_valid); end
    tick();
    drain_start = 1; tick(); drain_start = 0;
    checks++; if (psum_out !== 40'd0 || psum_out_valid !== 1'b1) begin failures++; $display("FAIL sim_drain_cleared got=%0d/%b exp=0/1", psum_out, psum_out_valid); end
    tick();

    mac_op(16'd5, 16'd10, 1);
    input_top = 16'd2; input_left = 16'd3; valid_top = 1; valid_left = 1; acc_clear = 1; tick(); idle_inputs();
    drain_start = 1; tick(); drain_start = 0;
    checks++; if (psum_out !== 40'd6) begin failures++; $display("FAIL sim_clear_mac got=%0d exp=6", psum_out); end
    tick();

    mac_op(16'd4, 16'd4, 1);
    drain_start = 1; fwd_count = 6'd1; tick(); drain_start = 0;
    checks++; if (psum_out !== 40'd16) begin failures++; $display("FAIL sim_emit16 got=%0d exp=16", psum_out); end
    tick();
    drain_start = 1; fwd_count = 6'd5; tick(); drain_start = 0;
    checks++; if (psum_out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL sim_busy_ignore got=%b/%b exp=0/1", psum_out_valid, busy); end
    psum_in = 40'd77; psum_in_valid = 1; tick(); psum_in_valid = 0;
    checks++; if (psum_out !== 40'd77 || psum_out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL sim_count_kept got=%0d/%b/%b exp=77/1/0", psum_out, psum_out_valid, busy); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    mac_op(16'd6, 16'd7, 1);
    drain_start = 1; fwd_count = 6'd3; tick(); drain_start = 0;
    tick();
    psum_in = 40'd21; psum_in_valid = 1; tick();
    input_top = 16'h1111; input_left = 16'h2222; valid_top = 1; valid_left = 1;
    reset_accumulator = 1; tick(); reset_accumulator = 0;
    checks++; if (psum_out !== '0 || psum_out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_psum got=%h/%b/%b exp=0/0/0", psum_out, psum_out_valid, busy); end
    checks++; if (output_bottom !== '0 || output_right !== '0 || valid_bottom !== 1'b0 || valid_right !== 1'b0) begin failures++; $display("FAIL rstmid_fwd got=%h/%h exp=0/0", output_bottom, output_right); end
    idle_inputs();
    input_top = 16'd2; input_left = 16'd2; valid_top = 1; valid_left = 1; drain_start = 1; tick(); idle_inputs();
    checks++; if (psum_out !== 40'd4 || psum_out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_redrain got=%0d/%b/%b exp=4/1/1", psum_out, psum_out_valid, busy); end
    tick();
  endtask

  task automatic test_acc32_limit();
    do_reset();
    mac_op(16'sd32767, 16'sd32767, 3);
`ifdef PE_MAC_SAT_EN
    checks++; if (sat32 !== 1'b1) begin failures++; $display("FAIL sat_flag_set got=%b exp=1", sat32); end
`endif
    drain_start = 1; fwd_count = '0; tick(); drain_start = 0;
`ifdef PE_MAC_SAT_EN
    checks++; if (longint'($signed(po32)) !== 64'sd2147483647) begin failures++; $display("FAIL sat_clamp got=%0d exp=2147483647", $signed(po32)); end
    checks++; if (sat32 !== 1'b0) begin failures++; $display("FAIL sat_flag_drain got=%b exp=0", sat32); end
`else
    checks++; if (longint'($signed(po32)) !== -64'sd1073938429) begin failures++; $display("FAIL wrap32 got=%0d exp=-1073938429", $signed(po32)); end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [63:0] r64;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset_accumulator = ($urandom_range(63) == 0);
      valid_top = 1'($urandom_range(1)); valid_left = 1'($urandom_range(1));
      input_top = 16'($urandom()); input_left = 16'($urandom());
      drain_start = ($urandom_range(5) == 0); acc_clear = ($urandom_range(11) == 0);
      fwd_count = 6'($urandom_range(3));
      r64 = {$urandom(), $urandom()}; psum_in = r64[AW-1:0];
      psum_in_valid = 1'($urandom_range(1));
      tick();
      checks++; if (output_bottom !== e_bottom || valid_bottom !== e_vb) begin failures++; $display("FAIL rnd_bottom cyc=%0d got=%h/%b exp=%h/%b", i, output_bottom, valid_bottom, e_bottom, e_vb); end
      checks++; if (output_right !== e_right || valid_right !== e_vr) begin failures++; $display("FAIL rnd_right cyc=%0d got=%h/%b exp=%h/%b", i, output_right, valid_right, e_right, e_vr); end
      checks++; if (psum_out !== e_po || psum_out_valid !== e_pv) begin failures++; $display("FAIL rnd_psum cyc=%0d got=%h/%b exp=%h/%b", i, psum_out, psum_out_valid, e_po, e_pv); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, e_busy); end
    end
    reset_accumulator = 0;
    idle_inputs();
  endtask

  initial begin
    reset_accumulator = 0;
    idle_inputs();
    test_reset();
    test_mac_drain();
    test_forward_drain();
    test_simultaneous();
    test_reset_mid_drain();
    test_acc32_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
